// File: rtl/pio_pkg.sv
// Shared definitions for the blinking output PIO.
//   - Register word addresses of the Avalon-MM slave.
//   - Bit position of the blink phase inside the STATUS register.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_BLINK  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int PHASE_BIT = 0;

endpackage

// File: rtl/pio_output_blink_if.sv
// Avalon-MM slave bus for the blinking output PIO.
//   address    : 3-bit register word select
//   chipselect : slave select
//   write_n    : active-low write strobe (write = chipselect & ~write_n)
//   writedata  : 32-bit write data
//   readdata   : 32-bit combinational read data from the slave
interface pio_output_blink_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_output_blink_timer.sv
// Shared blink timer: holds the half-period register, the free-running
// counter and the phase bit.
//   clk          : system clock, rising edge
//   reset        : synchronous active-high reset
//   period_we    : load a new half-period (restarts counter and phase)
//   period_wdata : new half-period value
//   period       : current half-period register
//   counter      : current counter value
//   phase        : blink phase, toggles every period+1 cycles
module blink_timer #(
    parameter int                     PERIOD_W     = 24,
    parameter logic [PERIOD_W-1:0]    PERIOD_RESET = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                period_we,
    input  logic [PERIOD_W-1:0] period_wdata,
    output logic [PERIOD_W-1:0] period,
    output logic [PERIOD_W-1:0] counter,
    output logic                phase
);

    // NOTE: reset is tested first inside the clocked block, so it is
    // synchronous and wins over every load in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            period  <= PERIOD_RESET;
            counter <= '0;
            phase   <= 1'b0;
        end else if (period_we) begin
            // A new period restarts the blink cycle, overriding a wrap
            // that would otherwise happen on this edge.
            period  <= period_wdata;
            counter <= '0;
            phase   <= 1'b0;
        end else if (counter == period) begin
            counter <= '0;
            phase   <= ~phase;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            counter <= counter + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/pio_output_blink.sv
// Parametrised Avalon-MM output PIO with atomic set/clear and per-bit blink.
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata); zero wait states, combinational read
//   out_port : WIDTH output pins = DATA & (~BLINK_EN | {WIDTH{phase}})
module pio_output_blink
    import pio_pkg::*;
#(
    parameter int                  WIDTH        = 8,
    parameter int                  PERIOD_W     = 24,
    parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = '0
) (
    input  logic                clk,
    input  logic                reset,
    pio_output_blink_if.slave   bus,
    output logic [WIDTH-1:0]    out_port
);

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    blink_en_q;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] counter;
    logic                phase;

    logic                wr;
    logic [WIDTH-1:0]    wd_bits;
    logic [32:0]         status_wide;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wd_bits = bus.writedata[WIDTH-1:0];

    // Only the low WIDTH / PERIOD_W bits of writedata are architected.
    wire unused_writedata = &{1'b0, bus.writedata};
    wire unused_status    = status_wide[32];

    blink_timer #(
        .PERIOD_W     (PERIOD_W),
        .PERIOD_RESET (PERIOD_RESET)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .period_we    (wr && (bus.address == ADDR_PERIOD)),
        .period_wdata (bus.writedata[PERIOD_W-1:0]),
        .period       (period),
        .counter      (counter),
        .phase        (phase)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:  data_q     <= wd_bits;
                ADDR_SET:   data_q     <= data_q | wd_bits;
                ADDR_CLR:   data_q     <= data_q & ~wd_bits;
                ADDR_BLINK: blink_en_q <= wd_bits;
                default:    ;
            endcase
        end
    end

    // STATUS packs the phase at bit 0 and the counter above it; the 33-bit
    // staging vector lets a 32-bit counter lose its top bit cleanly.
    always_comb begin
        status_wide             = '0;
        status_wide[PERIOD_W:1] = counter;
        status_wide[PHASE_BIT]  = phase;
    end

    // chipselect intentionally does not gate the read mux.
    always_comb begin
        // NOTE: default first so every path assigns readdata; no latch.
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata = 32'(data_q);
            ADDR_BLINK:  bus.readdata = 32'(blink_en_q);
            ADDR_PERIOD: bus.readdata = 32'(period);
            ADDR_STATUS: bus.readdata = status_wide[31:0];
            default:     bus.readdata = '0;
        endcase
    end

    assign out_port = data_q & (~blink_en_q | {WIDTH{phase}});

endmodule
